// File: rtl/div_controller.sv
// Sequencing wrapper for an unsigned iterative divider: RISC-V DIV/DIVU/REM/REMU with sign fix-up and bypasses.
// Latency: bypass 1 cycle after acceptance; normal START + divider cycles + FIX + 1; WAIT aborts after TIMEOUT_CYCLES.
// Backpressure: one op in flight, req_ready_o only in IDLE; the response is held in RESP until resp_ready_i.
module div_controller #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] result_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        div_start_o,
    output logic [31:0] div_num_o,
    output logic [31:0] div_den_o,
    input  logic [31:0] div_quot_i,
    input  logic [31:0] div_rem_i,
    input  logic        div_done_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_FIX, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q;
    logic          rs1_neg_q, rs2_neg_q;
    logic [31:0]   num_q, den_q, quot_q, rem_q, result_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic          accept, is_signed, div_zero, ovf, bypass, timeout;
    logic [31:0]   bypass_res, fix_res;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    assign accept    = req_valid_i && (state_q == S_IDLE);
    assign is_signed = ~op_i[0];
    assign div_zero  = (rs2_i == 32'd0);
    assign ovf       = is_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    assign bypass    = div_zero || ovf;
    assign timeout   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Divide-by-zero takes precedence; ovf cannot coincide with it anyway.
    assign bypass_res = div_zero ? (op_i[1] ? rs1_i : 32'hFFFF_FFFF)
                                 : (op_i[1] ? 32'd0 : 32'h8000_0000);

    always_comb begin
        fix_res = quot_q;
        case (op_q)
            2'b00:   fix_res = (rs1_neg_q ^ rs2_neg_q) ? neg32(quot_q) : quot_q;
            2'b01:   fix_res = quot_q;
            2'b10:   fix_res = rs1_neg_q ? neg32(rem_q) : rem_q;
            default: fix_res = rem_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = bypass ? S_RESP : S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (div_done_i) state_d = S_FIX;
                     else if (timeout) state_d = S_RESP;
            S_FIX:   state_d = S_RESP;
            S_RESP:  if (resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= 2'b00;
            rs1_neg_q <= 1'b0;
            rs2_neg_q <= 1'b0;
            num_q     <= 32'd0;
            den_q     <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            result_q  <= 32'd0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        op_q      <= op_i;
                        rs1_neg_q <= is_signed && rs1_i[31];
                        rs2_neg_q <= is_signed && rs2_i[31];
                        num_q     <= (is_signed && rs1_i[31]) ? neg32(rs1_i) : rs1_i;
                        den_q     <= (is_signed && rs2_i[31]) ? neg32(rs2_i) : rs2_i;
                        result_q  <= bypass_res;
                        err_q     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (div_done_i) begin
                        quot_q <= div_quot_i;
                        rem_q  <= div_rem_i;
                    end else if (timeout) begin
                        result_q <= 32'd0;
                        err_q    <= 1'b1;
                    end
                end
                S_FIX: begin
                    result_q <= fix_res;
                    err_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while rst_i is high, even before the reset edge lands.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        result_o     = 32'd0;
        err_o        = 1'b0;
        busy_o       = 1'b0;
        div_start_o  = 1'b0;
        div_num_o    = 32'd0;
        div_den_o    = 32'd0;
        if (!rst_i) begin
            busy_o = (state_q != S_IDLE);
            case (state_q)
                S_IDLE:  req_ready_o = 1'b1;
                S_START: begin
                    div_start_o = 1'b1;
                    div_num_o   = num_q;
                    div_den_o   = den_q;
                end
                S_WAIT: begin
                    div_num_o = num_q;
                    div_den_o = den_q;
                end
                S_RESP: begin
                    resp_valid_o = 1'b1;
                    result_o     = result_q;
                    err_o        = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles in WAIT before abort.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, synchronous active-high reset.
REQ-003 SHALL have ports:
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_i  in  32  dividend
- rs2_i  in  32  divisor
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- result_o  out  32  final result
- err_o  out  1  timeout flag, qualified by resp_valid_o
- busy_o  out  1  state not IDLE
- div_start_o  out  1  one-cycle start pulse to the unsigned divider
- div_num_o  out  32  unsigned numerator to divider
- div_den_o  out  32  unsigned denominator to divider
- div_quot_i  in  32  divider quotient, valid when div_done_i=1
- div_rem_i  in  32  divider remainder, valid when div_done_i=1
- div_done_i  in  1  divider completion pulse

Function
REQ-004 SHALL implement states IDLE, START, WAIT, FIX, RESP.
REQ-005 SHALL drive req_ready_o=1 only in IDLE; a request is accepted when req_valid_i & req_ready_o; op_i, rs1_i and rs2_i are registered on acceptance.
REQ-006 SHALL classify the accepted request: signed = (op_i[0]==0); divisor-zero = (rs2_i==0); overflow = signed & rs1_i==32'h80000000 & rs2_i==32'hFFFFFFFF.
REQ-007 SHALL, on divisor-zero, bypass the divider and go IDLE->RESP with result 32'hFFFFFFFF for DIV/DIVU and rs1 for REM/REMU.
REQ-008 SHALL, on overflow, bypass the divider and go IDLE->RESP with result 32'h80000000 for DIV and 0 for REM.
REQ-009 SHALL otherwise go IDLE->START, with div_num_o = |rs1| and div_den_o = |rs2| (two's-complement magnitude) for signed ops, and raw values for unsigned ops.
REQ-010 SHALL hold div_num_o and div_den_o stable from START until leaving WAIT, and drive them 0 in IDLE.
REQ-011 SHALL assert div_start_o for exactly one cycle, in START, then go to WAIT.
REQ-012 SHALL ignore div_done_i in every state except WAIT; in WAIT, div_done_i=1 captures div_quot_i and div_rem_i and moves to FIX.
REQ-013 SHALL count WAIT cycles; if the count reaches TIMEOUT_CYCLES without div_done_i, go to RESP with result 0 and err_o=1; otherwise err_o=0.
REQ-014 SHALL, in FIX:
- DIV result = quotient negated when rs1[31]^rs2[31];
- REM result = remainder negated when rs1[31];
- DIVU/REMU pass unchanged;
- then go to RESP.
REQ-015 SHALL hold resp_valid_o=1 with stable result_o and err_o in RESP until resp_ready_i=1, then return to IDLE on the next edge.
REQ-016 SHALL not accept a new request in the same cycle as a response handshake.
REQ-017 SHALL have latency: bypass = resp_valid_o one cycle after acceptance; normal = acceptance + 1 (START) + divider cycles + 1 (FIX) + 1.
REQ-018 SHALL use 32-bit modulo arithmetic for all negations; negating 0 yields 0.
REQ-019 SHALL assert busy_o = (state != IDLE).

Reset
REQ-020 SHALL, with rst_i=1 at a clock edge, force state to IDLE from any state, including mid-WAIT, and clear captured operands, the timeout counter and the result register.
REQ-021 SHALL drive these outputs during reset: resp_valid_o=0, result_o=0, err_o=0, div_start_o=0, div_num_o=0, div_den_o=0, busy_o=0.
REQ-022 SHALL have req_ready_o=1 in the first cycle after rst_i deasserts.
REQ-023 SHALL ignore, after reset, any div_done_i belonging to an aborted operation, because it is only honoured in WAIT.

Verification
REQ-024 SHALL cover DIVU rs1=100, rs2=7 -> exactly one div_start_o pulse, div_num_o=100, div_den_o=7; divider returns 14/2 -> result_o=14, err_o=0.
REQ-025 SHALL cover DIV rs1=-7 (FFFFFFF9), rs2=2 -> div_num_o=7, div_den_o=2; DIV result_o=FFFFFFFD (-3); REM same operands -> result_o=FFFFFFFF (-1).
REQ-026 SHALL cover DIVU x/0 -> result_o=FFFFFFFF; REMU 5/0 -> result_o=5; DIV 80000000/FFFFFFFF -> result_o=80000000; in all three, div_start_o never asserts and resp_valid_o rises one cycle after acceptance.
REQ-027 SHALL cover resp_ready_i held 0 for 5 cycles -> resp_valid_o and result_o stable throughout, req_ready_o=0, then return to IDLE one cycle after resp_ready_i=1.
REQ-028 SHALL cover div_done_i never asserted with TIMEOUT_CYCLES=64 -> RESP entered after 64 WAIT cycles, result_o=0, err_o=1.
REQ-029 SHALL cover rst_i pulsed during WAIT, followed by a late div_done_i -> IDLE, no resp_valid_o, req_ready_o=1 in the first cycle after reset.
